// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Every memory access is bounded by a timeout that completes the access with an error response.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    // state   | meaning
    // IDLE    | no access in flight; arbitrate pending requests
    // BUSY_IF | memory access on behalf of the fetch port
    // BUSY_D  | memory access on behalf of the load/store port
    // RESP    | one-cycle ack to the served port; requests ignored

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t           state, state_next;
    logic             last_grant_d;
    logic [CNT_W-1:0] cnt;
    logic             hit, expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        hit        = 1'b0;
        expire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (if_req && d_req) state_next = last_grant_d ? BUSY_IF : BUSY_D;
                else if (if_req)     state_next = BUSY_IF;
                else if (d_req)      state_next = BUSY_D;
            end
            BUSY_IF, BUSY_D: begin
                mem_req = 1'b1;
                if (state == BUSY_IF) begin
                    mem_addr = if_addr;
                    mem_be   = '1;
                end else begin
                    mem_we    = d_we;
                    mem_be    = d_be;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end
                if (mem_ready) begin
                    hit        = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant history and the per-access wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_d <= 1'b0;
            cnt          <= '0;
        end else begin
            if (state == IDLE && state_next == BUSY_IF) last_grant_d <= 1'b0;
            if (state == IDLE && state_next == BUSY_D)  last_grant_d <= 1'b1;
            if ((state == BUSY_IF || state == BUSY_D) && !hit && !expire)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // Registered responses: acks pulse during RESP, data/error hold until the next completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if_ack <= (state == BUSY_IF) && (hit || expire);
            d_ack  <= (state == BUSY_D)  && (hit || expire);
            if (state == BUSY_IF && (hit || expire)) begin
                if_rdata <= hit ? mem_rdata : '0;
                if_err   <= expire;
            end
            if (state == BUSY_D && (hit || expire)) begin
                d_rdata <= hit ? mem_rdata : '0;
                d_err   <= expire;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store with wait states, arbitration order,
// timeout, asynchronous reset mid-access and back-to-back fetch throughput.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_ack, if_err;
    logic                d_req, d_we;
    logic [DATA_W/8-1:0] d_be;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata, d_rdata;
    logic                d_ack, d_err;
    logic                mem_req, mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;
    logic                mem_ready;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] all_out;
        return {32'h0, if_ack, if_err, d_ack, d_err, mem_req, mem_we, mem_be, mem_addr[21:0]}
               | {if_rdata, 32'h0} | {d_rdata, 32'h0} | {mem_wdata, 32'h0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, ack_tick, n_ack;
        logic seen;
        logic [ADDR_W-1:0] exp_addr;

        rst = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
        #3;
        check("reset_outputs", all_out(), 64'h0);
        do_reset();
        #1;
        check("post_reset_outputs", all_out(), 64'h0);

        // single zero-wait fetch
        tick();
        if_req = 1; if_addr = 32'h4; mem_ready = 1; mem_rdata = 32'h0010_0093;
        tick();
        check("f1_mem_req", mem_req, 1);
        check("f1_mem_fields", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h4});
        check("f1_no_ack_yet", if_ack, 0);
        tick();
        check("f1_if_ack", {if_ack, d_ack, mem_req}, 3'b100);
        check("f1_if_rdata", if_rdata, 32'h0010_0093);
        check("f1_if_err", if_err, 0);
        if_req = 0; mem_ready = 0;
        tick();
        check("f1_ack_one_cycle", if_ack, 0);

        // store with three wait states
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_mem_req", mem_req, 1);
            check("st_fields", {mem_we, mem_be, mem_addr[15:0], mem_wdata},
                  {1'b1, 4'h3, 16'h0100, 32'hDEAD_BEEF});
            check("st_no_early_ack", {if_ack, d_ack}, 2'b00);
            if (i == 3) mem_ready = 1;
        end
        tick();
        check("st_d_ack", {if_ack, d_ack, d_err, mem_req}, 4'b0100);
        check("st_d_rdata", d_rdata, 32'h1234_5678);
        d_req = 0; d_we = 0; mem_ready = 0;
        tick();
        check("st_ack_one_cycle", d_ack, 0);

        // simultaneous requests after reset: D, IF, D, IF
        do_reset();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h80; d_be = 4'hF; mem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_grant_addr", mem_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
            tick();
            check("rr_acks", {if_ack, d_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_idle", mem_req, 0);
        end
        if_req = 0; d_req = 0; mem_ready = 0;
        tick();

        // timeout on an unresponsive memory
        d_req = 1; d_we = 0; d_addr = 32'h200; mem_rdata = 32'hFFFF_FFFF;
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (mem_req) n++;
            if (d_ack) seen = 1;
        end
        check("to_ack_seen", seen, 1);
        check("to_busy_cycles", n, TIMEOUT);
        check("to_d_err", d_err, 1);
        check("to_d_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        d_req = 1; mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        tick();
        check("to_recover_req", mem_req, 1);
        tick();
        check("to_recover_ack", {d_ack, d_err}, 2'b10);
        check("to_recover_rdata", d_rdata, 32'hCAFE_0001);
        d_req = 0; mem_ready = 0;
        tick();

        // reset asserted in the second BUSY cycle
        if_req = 1; if_addr = 32'h8;
        tick();
        tick();
        check("rst_mid_busy", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs", all_out(), 64'h0);
        if_req = 0;
        tick();
        check("rst_no_ack", {if_ack, d_ack, mem_req}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        if_req = 1; if_addr = 32'hC; mem_ready = 1; mem_rdata = 32'h0000_0013;
        tick();
        check("rst_fresh_req", {mem_req, mem_addr[7:0]}, 9'h10C);
        tick();
        check("rst_fresh_ack", {if_ack, if_err}, 2'b10);
        check("rst_fresh_rdata", if_rdata, 32'h13);
        if_req = 0;
        tick();

        // stale mem_ready in IDLE, then a back-to-back fetch stream
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_ready_quiet", {mem_req, if_ack, d_ack}, 3'b000);
        end
        if_req = 1; if_addr = 32'h0; exp_addr = 32'h0; mem_rdata = 32'h0000_0013;
        n_ack = 0; ack_tick = 0;
        for (int t = 1; t <= 12 && n_ack < 3; t++) begin
            tick();
            if (mem_req) check("fetch_addr", mem_addr, exp_addr);
            if (if_ack) begin
                n_ack++;
                check("fetch_rdata", if_rdata, 32'h13);
                if (n_ack == 3) begin
                    ack_tick = t;
                    if_req = 0;
                end else begin
                    if_addr = if_addr + 32'h4;
                    exp_addr = exp_addr + 32'h4;
                end
            end
        end
        check("fetch_ack_count", n_ack, 3);
        check("fetch_third_ack_tick", ack_tick, 8);
        tick();
        check("fetch_back_idle", {mem_req, if_ack}, 2'b00);
        mem_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port unified memory between the core's instruction-fetch port (IF) and its load/store port (D).
- Sits between the riscv_chip core and the memory model / bus.
- Serialises accesses with a round-robin grant and returns one-cycle acks.
- Bounds every memory access with a timeout that reports a bus error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 16, maximum cycles in BUSY waiting for mem_ready before an error response; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- if_err  out  1  IF timeout error; valid with if_ack.
- d_req  in  1  data request; level, held with all d_* fields stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables for stores.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for D.
- d_err  out  1  D timeout error; valid with d_ack.
- mem_req  out  1  memory request; held until mem_ready is sampled high or the timeout fires.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  memory completion; ignored when mem_req=0.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D, RESP. Reset enters IDLE.
- Reset values:
  - all outputs 0;
  - last_grant = IF;
  - timeout counter = 0;
  - rdata registers = 0.
- IDLE:
  - Only if_req=1: go to BUSY_IF.
  - Only d_req=1: go to BUSY_D.
  - Both: grant the port not served last (last_grant=IF -> BUSY_D, else BUSY_IF).
  - Neither: stay in IDLE.
  - last_grant updates on entry to BUSY_x.
- BUSY_x:
  - mem_req=1 is decoded from state.
  - mem_addr/mem_we/mem_be/mem_wdata are muxed combinationally from the granted port.
  - For IF: mem_we=0, mem_be=all ones, mem_wdata=0.
  - In IDLE and RESP: mem_req=0, remaining mem_* outputs = 0.
  - On an edge with mem_ready=1: capture mem_rdata into x_rdata, set x_err=0, go to RESP.
  - The counter increments each BUSY cycle without ready. When counter reaches TIMEOUT-1 without ready: x_rdata=0, x_err=1, go to RESP. The counter clears on leaving BUSY.
- RESP:
  - Exactly one of if_ack/d_ack = 1, matching the granted port, for one cycle. Acks are registered outputs.
  - Requests are ignored in this cycle, because the requester still holds req.
  - Next state is always IDLE.
  - A request asserted during RESP is arbitrated in IDLE.
- Latency:
  - Request seen at edge t0 with zero-wait memory (mem_ready=1 at t1): ack high in cycle t1..t2.
  - Minimum 3 cycles per transaction (BUSY, RESP, IDLE).
  - A request present in IDLE is never skipped.
  - No starvation: under continuous dual requests, grants strictly alternate.
- x_rdata and x_err hold their last value outside ack; they are valid only with ack.
- mem_ready=1 while mem_req=0 has no effect.
- Protocol violation: a requester dropping req mid-transaction does not abort it; the ack still issues.
- Reset asserted mid-transaction:
  - immediate return to IDLE;
  - mem_req drops asynchronously;
  - no ack issued.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x0000_0004, mem_ready=1, mem_rdata=0x0010_0093. Required: mem_req high 1 cycle with mem_addr=0x4, mem_we=0, mem_be=0xF; if_ack 1 cycle later with if_rdata=0x0010_0093, if_err=0.
- Store with 3 wait states: d_we=1, d_be=0x3, d_addr=0x100, d_wdata=0xDEAD_BEEF. Required: mem_req held 4 cycles with fields stable; d_ack after mem_ready; no if_ack.
- Simultaneous requests after reset: IF and D both high continuously for 4 transactions. Required: grant order D, IF, D, IF (last_grant resets to IF).
- Timeout: d_req to unresponsive memory, TIMEOUT=16. Required: mem_req high exactly 16 cycles, then d_ack=1, d_err=1, d_rdata=0; next access succeeds normally.
- Reset mid-operation: assert rst low during the 2nd BUSY cycle. Required: mem_req=0, no ack, all outputs 0 immediately; after release, IDLE and a fresh if_req completes normally.
- Stale mem_ready: mem_ready=1 while IDLE, then if_req issued. Required: no spurious ack; PC-driving fetch sequence 0x0, 0x4, 0x8 completes in 9 cycles with zero-wait memory.
